// File: rtl/i2s_target_receiver.sv
// ---------------------------------------------------------------------------
// i2s_target_receiver
//
// Receive-side I2S target. SCLK, LRCK and SDATA are driven by an external
// controller and are sampled into the clk domain through equal-depth
// synchronizer chains. Each left/right half-frame is deserialized MSB first;
// the top DataWidth bits of each channel word are presented as a stereo pair.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   sclkIn       asynchronous serial bit clock from the controller
//   lrckIn       asynchronous word select (0 = left, 1 = right)
//   sdataIn      asynchronous serial data, MSB first, two's complement
//   leftData     last committed left sample (top DataWidth bits)
//   rightData    last committed right sample (top DataWidth bits)
//   sampleValid  one-cycle pulse when leftData/rightData update together
//   frameError   one-cycle pulse when a half-frame is rejected
//   locked       high while the receiver is tracking frames
// ---------------------------------------------------------------------------
module i2s_target_receiver #(
    parameter int DataWidth       = 12,
    parameter int SerialDataWidth = 24,
    parameter int SyncStages      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclkIn,
    input  logic                 lrckIn,
    input  logic                 sdataIn,
    output logic [DataWidth-1:0] leftData,
    output logic [DataWidth-1:0] rightData,
    output logic                 sampleValid,
    output logic                 frameError,
    output logic                 locked
);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_RECEIVE  = 1'b1
    } state_t;

    localparam logic [6:0] SERIAL_W  = 7'(SerialDataWidth);
    localparam logic [6:0] DATA_W    = 7'(DataWidth);
    localparam logic [5:0] MAX_INDEX = 6'd63;

    logic [SyncStages-1:0] sclk_sync_r;
    logic [SyncStages-1:0] lrck_sync_r;
    logic [SyncStages-1:0] sdata_sync_r;
    logic                  sclk_prev_r;
    logic                  prev_ws_r;
    logic                  have_prev_r;

    logic                  sclk_s;
    logic                  ws_s;
    logic                  data_s;
    logic                  rise_s;
    logic                  boundary_s;
    logic [6:0]            half_len_s;
    logic                  half_ok_s;

    state_t                state_r;
    state_t                state_next_s;

    logic                  lock_s;
    logic                  restart_s;
    logic                  capture_s;
    logic                  commit_s;
    logic                  short_err_s;
    logic                  overrun_s;
    logic                  count_s;
    logic                  shift_s;

    logic [5:0]            bit_index_r;
    logic [DataWidth-1:0]  shift_r;
    logic [DataWidth-1:0]  left_stage_r;
    logic                  left_captured_r;
    logic [DataWidth-1:0]  left_data_r;
    logic [DataWidth-1:0]  right_data_r;
    logic                  sample_valid_r;
    logic                  frame_error_r;
    logic                  locked_r;

    // Synchronizer chains for all three pins plus the delayed SCLK copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_r  <= '0;
            lrck_sync_r  <= '0;
            sdata_sync_r <= '0;
            sclk_prev_r  <= 1'b0;
        end else begin
            sclk_sync_r  <= {sclk_sync_r[SyncStages-2:0], sclkIn};
            lrck_sync_r  <= {lrck_sync_r[SyncStages-2:0], lrckIn};
            sdata_sync_r <= {sdata_sync_r[SyncStages-2:0], sdataIn};
            sclk_prev_r  <= sclk_sync_r[SyncStages-1];
        end
    end

    assign sclk_s = sclk_sync_r[SyncStages-1];
    assign ws_s   = lrck_sync_r[SyncStages-1];
    assign data_s = sdata_sync_r[SyncStages-1];
    assign rise_s = sclk_s & ~sclk_prev_r;
    // The first rise after reset has no earlier LRCK to compare against, so it never counts as a boundary.
    assign boundary_s = rise_s & have_prev_r & (ws_s ^ prev_ws_r);
    // Length of the half-frame that ends at this boundary; the 6-bit index caps it at 64.
    assign half_len_s = {1'b0, bit_index_r} + 7'd1;
    assign half_ok_s  = (half_len_s >= SERIAL_W);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_UNLOCKED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: lock on any boundary, drop lock on counter overrun.
    always_comb begin
        state_next_s = ST_UNLOCKED;
        case (state_r)
            ST_UNLOCKED: begin
                if (boundary_s) begin
                    state_next_s = ST_RECEIVE;
                end else begin
                    state_next_s = ST_UNLOCKED;
                end
            end
            ST_RECEIVE: begin
                if (overrun_s) begin
                    state_next_s = ST_UNLOCKED;
                end else begin
                    state_next_s = ST_RECEIVE;
                end
            end
            default: state_next_s = ST_UNLOCKED;
        endcase
    end

    // Event decode for the current SCLK rise; at most one event fires per rise.
    always_comb begin
        lock_s      = 1'b0;
        restart_s   = 1'b0;
        capture_s   = 1'b0;
        commit_s    = 1'b0;
        short_err_s = 1'b0;
        overrun_s   = 1'b0;
        count_s     = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            ST_UNLOCKED: begin
                if (boundary_s) begin
                    lock_s = 1'b1;
                end else begin
                    lock_s = 1'b0;
                end
            end
            ST_RECEIVE: begin
                if (boundary_s) begin
                    restart_s = 1'b1;
                    if (!half_ok_s) begin
                        short_err_s = 1'b1;
                    end else if (ws_s) begin
                        // LRCK went high: the left half just ended.
                        capture_s = 1'b1;
                    end else if (left_captured_r) begin
                        commit_s = 1'b1;
                    end else begin
                        commit_s = 1'b0;
                    end
                end else if (rise_s) begin
                    if (bit_index_r == MAX_INDEX) begin
                        overrun_s = 1'b1;
                    end else begin
                        count_s = 1'b1;
                        shift_s = ({1'b0, bit_index_r} < DATA_W);
                    end
                end else begin
                    count_s = 1'b0;
                end
            end
            default: begin
                lock_s = 1'b0;
            end
        endcase
    end

    // Bit counter, shift register, left staging and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ws_r       <= 1'b0;
            have_prev_r     <= 1'b0;
            bit_index_r     <= 6'd0;
            shift_r         <= '0;
            left_stage_r    <= '0;
            left_captured_r <= 1'b0;
            left_data_r     <= '0;
            right_data_r    <= '0;
            sample_valid_r  <= 1'b0;
            frame_error_r   <= 1'b0;
            locked_r        <= 1'b0;
        end else begin
            if (rise_s) begin
                prev_ws_r   <= ws_s;
                have_prev_r <= 1'b1;
            end
            if (lock_s || restart_s || overrun_s) begin
                bit_index_r <= 6'd0;
                shift_r     <= '0;
            end else if (count_s) begin
                bit_index_r <= bit_index_r + 6'd1;
                if (shift_s) begin
                    shift_r <= {shift_r[DataWidth-2:0], data_s};
                end
            end
            if (capture_s) begin
                left_stage_r    <= shift_r;
                left_captured_r <= 1'b1;
            end else if (lock_s || short_err_s || overrun_s || (restart_s && !ws_s)) begin
                // A right half ending always consumes (or abandons) any staged left word.
                left_captured_r <= 1'b0;
            end
            if (commit_s) begin
                left_data_r  <= left_stage_r;
                right_data_r <= shift_r;
            end
            sample_valid_r <= commit_s;
            frame_error_r  <= short_err_s | overrun_s;
            locked_r       <= (state_next_s == ST_RECEIVE);
        end
    end

    assign leftData    = left_data_r;
    assign rightData   = right_data_r;
    assign sampleValid = sample_valid_r;
    assign frameError  = frame_error_r;
    assign locked      = locked_r;

endmodule

// File: tb/tb_i2s_target_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_target_receiver
//
// Drives I2S half-frames (LRCK/SDATA change on SCLK fall) into the receiver
// and checks every sampleValid/frameError event, the held outputs and the
// lock indication against a half-frame level reference model.
// ---------------------------------------------------------------------------
module tb_i2s_target_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclkIn;
    logic        lrckIn;
    logic        sdataIn;
    logic [11:0] leftData;
    logic [11:0] rightData;
    logic        sampleValid;
    logic        frameError;
    logic        locked;

    typedef struct packed {
        logic [1:0]  kind;   // 1 = sampleValid, 2 = frameError
        logic [11:0] l;
        logic [11:0] r;
        logic        lk;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    int assert_count  = 0;
    int fail_count    = 0;
    int overlap_count = 0;
    int half_period   = 3;

    // Reference model state, one step per half-frame.
    bit          m_locked;
    bit          m_left_cap;
    bit          m_have_prev;
    bit          m_last_ws;
    logic [11:0] m_left_stage;
    logic [11:0] m_left_out;
    logic [11:0] m_right_out;
    int          m_prev_n;
    logic [23:0] m_prev_word;

    i2s_target_receiver #(
        .DataWidth      (12),
        .SerialDataWidth(24),
        .SyncStages     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclkIn     (sclkIn),
        .lrckIn     (lrckIn),
        .sdataIn    (sdataIn),
        .leftData   (leftData),
        .rightData  (rightData),
        .sampleValid(sampleValid),
        .frameError (frameError),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Record every output event, sampled away from the active edge.
    always @(negedge clk) begin
        ev_t e;
        if (sampleValid && frameError) overlap_count++;
        if (sampleValid) begin
            e = {2'd1, leftData, rightData, locked};
            obs_q.push_back(e);
        end else if (frameError) begin
            e = {2'd2, leftData, rightData, locked};
            obs_q.push_back(e);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        assert_count++;
        if (got !== want) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind);
        ev_t e;
        e = {kind, m_left_out, m_right_out, m_locked};
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check_value({tag, "/ev_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_value({tag, "/ev_kind"},   {30'd0, obs_q[i].kind}, {30'd0, exp_q[i].kind});
            check_value({tag, "/ev_left"},   {20'd0, obs_q[i].l},    {20'd0, exp_q[i].l});
            check_value({tag, "/ev_right"},  {20'd0, obs_q[i].r},    {20'd0, exp_q[i].r});
            check_value({tag, "/ev_locked"}, {31'd0, obs_q[i].lk},   {31'd0, exp_q[i].lk});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Model of what happens when the half that just ended meets a new LRCK level.
    task automatic model_boundary(input logic ws);
        if (!m_locked) begin
            m_locked   = 1'b1;
            m_left_cap = 1'b0;
        end else if (m_prev_n < 24) begin
            push_exp(2'd2);
            m_left_cap = 1'b0;
        end else if (ws) begin
            m_left_stage = m_prev_word[23:12];
            m_left_cap   = 1'b1;
        end else begin
            if (m_left_cap) begin
                m_left_out  = m_left_stage;
                m_right_out = m_prev_word[23:12];
                push_exp(2'd1);
            end
            m_left_cap = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_left_cap  = 1'b0;
        m_left_out  = 12'd0;
        m_right_out = 12'd0;
    endtask

    task automatic send_bit(input logic ws, input logic d);
        sclkIn  = 1'b0;
        lrckIn  = ws;
        sdataIn = d;
        repeat (half_period) @(negedge clk);
        sclkIn = 1'b1;
        repeat (half_period) @(negedge clk);
    endtask

    // One half-frame of n SCLK periods at LRCK=ws. Slot 0 carries the previous
    // channel's last bit; slots 1..24 carry the word MSB first.
    // rst_at >= 0: before slot rst_at either pulse reset (rst_pulse) or release it.
    task automatic send_half(input string tag, input logic ws, input int n,
                             input logic [23:0] word, input int rst_at, input bit rst_pulse);
        logic d;
        if (m_have_prev && (ws != m_last_ws)) model_boundary(ws);
        if (reset == 1'b0) begin
            m_have_prev = 1'b1;
            m_last_ws   = ws;
        end
        if (m_locked && n > 64) begin
            m_locked   = 1'b0;
            m_left_cap = 1'b0;
            push_exp(2'd2);
        end
        m_prev_n    = n;
        m_prev_word = word;
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                if (rst_pulse) begin
                    compare_events({tag, "/pre_reset"});
                    reset = 1'b1;
                    @(negedge clk);
                    check_value({tag, "/rst_left"},   {20'd0, leftData},  32'd0);
                    check_value({tag, "/rst_right"},  {20'd0, rightData}, 32'd0);
                    check_value({tag, "/rst_valid"},  {31'd0, sampleValid}, 32'd0);
                    check_value({tag, "/rst_error"},  {31'd0, frameError},  32'd0);
                    check_value({tag, "/rst_locked"}, {31'd0, locked},      32'd0);
                    reset = 1'b0;
                    model_reset();
                end else begin
                    reset = 1'b0;
                end
                m_have_prev = 1'b1;
                m_last_ws   = ws;
            end
            if (k >= 1 && k <= 24) d = word[24-k];
            else d = 1'($urandom());
            send_bit(ws, d);
        end
        compare_events(tag);
        check_value({tag, "/locked"}, {31'd0, locked},    {31'd0, m_locked});
        check_value({tag, "/left"},   {20'd0, leftData},  {20'd0, m_left_out});
        check_value({tag, "/right"},  {20'd0, rightData}, {20'd0, m_right_out});
    endtask

    initial begin
        logic [23:0] w0;
        logic [23:0] w1;
        int n0;
        int n1;
        reset   = 1'b1;
        sclkIn  = 1'b0;
        lrckIn  = 1'b1;
        sdataIn = 1'b0;
        m_have_prev  = 1'b0;
        m_last_ws    = 1'b0;
        m_prev_n     = 0;
        m_prev_word  = 24'd0;
        m_left_stage = 12'd0;
        model_reset();

        repeat (3) @(negedge clk);
        check_value("reset/left",   {20'd0, leftData},    32'd0);
        check_value("reset/right",  {20'd0, rightData},   32'd0);
        check_value("reset/valid",  {31'd0, sampleValid}, 32'd0);
        check_value("reset/error",  {31'd0, frameError},  32'd0);
        check_value("reset/locked", {31'd0, locked},      32'd0);

        // Reset released partway through a right half, then nominal 64x frames.
        send_half("lockmid_r", 1'b1, 32, 24'($urandom()), 10, 1'b0);
        for (int f = 0; f < 3; f++) begin
            send_half("nom_l", 1'b0, 32, 24'h123456, -1, 1'b0);
            send_half("nom_r", 1'b1, 32, 24'hFEDCBA, -1, 1'b0);
        end

        // Random words, lengths and SCLK rates.
        for (int f = 0; f < 6; f++) begin
            half_period = $urandom_range(2, 4);
            w0 = 24'($urandom());
            w1 = 24'($urandom());
            n0 = $urandom_range(24, 64);
            n1 = $urandom_range(24, 64);
            send_half("rnd_l", 1'b0, n0, w0, -1, 1'b0);
            send_half("rnd_r", 1'b1, n1, w1, -1, 1'b0);
        end
        half_period = 3;

        // Short left half (N=20), then good frames.
        send_half("short_l", 1'b0, 20, 24'($urandom()), -1, 1'b0);
        send_half("short_r", 1'b1, 32, 24'($urandom()), -1, 1'b0);
        send_half("after_short_l", 1'b0, 32, 24'($urandom()), -1, 1'b0);
        send_half("after_short_r", 1'b1, 32, 24'($urandom()), -1, 1'b0);

        // Stuck LRCK for 70 rises, then relock and recover.
        send_half("stuck_l", 1'b0, 70, 24'($urandom()), -1, 1'b0);
        send_half("relock_r", 1'b1, 32, 24'($urandom()), -1, 1'b0);
        send_half("relock_l", 1'b0, 32, 24'($urandom()), -1, 1'b0);
        send_half("relock_r2", 1'b1, 32, 24'($urandom()), -1, 1'b0);

        // Length boundaries at the fastest SCLK.
        half_period = 2;
        send_half("len24_l", 1'b0, 24, 24'($urandom()), -1, 1'b0);
        send_half("len24_r", 1'b1, 24, 24'($urandom()), -1, 1'b0);
        send_half("len64_l", 1'b0, 64, 24'($urandom()), -1, 1'b0);
        send_half("len64_r", 1'b1, 64, 24'($urandom()), -1, 1'b0);
        send_half("len23_l", 1'b0, 23, 24'($urandom()), -1, 1'b0);
        send_half("len23_r", 1'b1, 32, 24'($urandom()), -1, 1'b0);
        send_half("len_ok_l", 1'b0, 32, 24'($urandom()), -1, 1'b0);
        send_half("len_ok_r", 1'b1, 32, 24'($urandom()), -1, 1'b0);
        half_period = 3;

        // One-cycle reset in the middle of a right half, then resume.
        send_half("pre_rst_l", 1'b0, 32, 24'($urandom()), -1, 1'b0);
        send_half("rst_r", 1'b1, 32, 24'($urandom()), 16, 1'b1);
        send_half("post_rst_l", 1'b0, 32, 24'($urandom()), -1, 1'b0);
        send_half("post_rst_r", 1'b1, 32, 24'($urandom()), -1, 1'b0);
        send_half("post_rst_l2", 1'b0, 32, 24'($urandom()), -1, 1'b0);
        send_half("post_rst_r2", 1'b1, 32, 24'($urandom()), -1, 1'b0);
        send_half("final_l", 1'b0, 32, 24'($urandom()), -1, 1'b0);

        check_value("valid_error_overlap", overlap_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/i2s_target_receiver.md
# i2s_target_receiver

Receive-side I2S target. It accepts externally driven SCLK, LRCK and SDATA from an I2S controller, synchronizes them into the `clk` domain and deserializes each left/right half-frame. It presents the top `DataWidth` bits of each 24-bit channel word as a stereo sample pair with a one-cycle valid pulse. It sits at the far end of the I2S2 link: it is the DAC-side consumer used in loopback tests, and the input path for boards where the codec or another device is the clock master.

## Interface
- `DataWidth`, 12: output bits per channel; must satisfy `DataWidth <= SerialDataWidth`.
- `SerialDataWidth`, 24: minimum data bits per half-frame; MSB first, two's complement.
- `SyncStages`, 2: synchronizer depth for each of `sclkIn`, `lrckIn` and `sdataIn`; minimum 2.
- `clk`  input  1  system clock.
- `reset`  input  1  reset, synchronous, active-high.
- `sclkIn`  input  1  asynchronous serial bit clock from the I2S controller.
- `lrckIn`  input  1  asynchronous word select; low = left, high = right.
- `sdataIn`  input  1  asynchronous serial data.
- `leftData`  output  DataWidth  last committed left sample.
- `rightData`  output  DataWidth  last committed right sample.
- `sampleValid`  output  1  one-cycle pulse when both `leftData` and `rightData` update.
- `frameError`  output  1  one-cycle pulse when a half-frame is rejected.
- `locked`  output  1  high while in RECEIVE.

## Operation
- **Input capture:** each input passes through its own `SyncStages`-flop chain. SCLK rise detection compares the last synchronizer stage with a one-cycle-delayed copy. LRCK and SDATA are taken from the same stage depth, so all three stay aligned.
- **Rise event:** on each detected SCLK rise, `ws` is the synchronized LRCK and `prevWs` is the LRCK value at the previous rise. A boundary is a rise where `ws != prevWs`.
- **Boundary bit:** the data bit at a boundary rise is the last slot of the previous channel and is discarded.
- **Counter:** `bitIndex` is 6 bits, cleared to 0 at each boundary and incremented on every non-boundary rise. While `bitIndex < DataWidth`, SDATA is shifted into the channel shift register (MSB first). The result is the top `DataWidth` bits of the 24-bit word: truncation, no rounding.
- **Half-frame length:** N = `bitIndex` + 1 at the next boundary. A half-frame is valid if `SerialDataWidth <= N <= 64`. A 64x master gives N = 32.
- **States:**
  - UNLOCKED: ignore data and wait for the first boundary. On that boundary, go to RECEIVE, clear `bitIndex`, clear `leftCaptured`.
  - RECEIVE, boundary with `ws`=1 (a left half just ended): if valid, copy the shift register to `leftStage` and set `leftCaptured`.
  - RECEIVE, boundary with `ws`=0 (a right half just ended): if valid and `leftCaptured`, load `leftData` from `leftStage` and `rightData` from the shift register, pulse `sampleValid`, then clear `leftCaptured`.
  - Short half-frame (N < `SerialDataWidth`): pulse `frameError`, discard the word, clear `leftCaptured`. Stay in RECEIVE; this boundary still restarts counting.
  - Overrun (a non-boundary rise arrives while `bitIndex == 63`): pulse `frameError`, clear `leftCaptured`, go to UNLOCKED.
- **Outputs:** `leftData` and `rightData` hold their value between commits and are never partially updated.
- **First frame:** if lock occurs at the start of a right half, that right word is dropped. The first `sampleValid` follows the first complete left+right pair.

## Timing
- Reset values: `leftData`=0, `rightData`=0, `sampleValid`=0, `frameError`=0, `locked`=0, state UNLOCKED, `bitIndex`=0, `leftCaptured`=0, synchronizers cleared.
- Reset mid-frame returns to these values on the next clk edge. Any partial word is lost.
- SCLK high and low phases must each be at least 2 `clk` periods. SDATA and LRCK must be stable for at least 2 `clk` periods around each SCLK rise.
- Rise detection latency: the first `clk` edge where SCLK=1 reaches the synchronizer output, plus 1 cycle for the edge compare. That is `SyncStages`+1 cycles after the pin rise.
- Commit latency: `sampleValid`, `frameError`, the output data updates and `locked` changes all occur in the cycle after the boundary rise is detected.
- `sampleValid` and `frameError` never assert in the same cycle. At most one event occurs per SCLK rise.

## Test plan
- **Nominal 64x frames:** left=0x123456, right=0xFEDCBA, repeated 3 frames. Required: `leftData`=0x123, `rightData`=0xFED; exactly one `sampleValid` per frame after the first pair; `locked`=1 after the first LRCK edge.
- **Lock mid-frame:** release reset during a right half. Required: no `sampleValid` until a full left then right has been received; first outputs are the values of that pair.
- **Short half-frame:** a left half with N=20. Required: one `frameError` pulse, no `sampleValid` for that frame, outputs hold their previous values; the next good frame commits normally.
- **Stuck LRCK:** 70 SCLK rises with no LRCK change. Required: `frameError` on rise 65; `locked` drops the next cycle; relock on the next LRCK edge; valid output after one more complete pair.
- **Boundary lengths:** N=24 and N=64 are accepted; N=23 sets `frameError`. Run with SCLK half-period = 2 clk.
- **Reset mid-frame:** assert `reset` for 1 cycle midway through a right half. Required: all outputs 0 the next cycle and `locked`=0; normal reception resumes afterwards.
